ipv4_arp_cam: RTL and testbench

//  Parametrised IPv4->MAC ARP table with per-entry valid bits and a banked, multi-cycle search engine.

---
 rtl/ipv4_arp_cam_pkg.sv | 17 +
 rtl/ipv4_arp_cam_bank_match.sv | 36 +++
 rtl/ipv4_arp_cam.sv | 224 ++++++++++++++++++++++
 tb/tb_ipv4_arp_cam.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ipv4_arp_cam_pkg.sv
// Shared definitions for the IPv4->MAC ARP table: FSM encoding, counter width,
// default MAC width and the all-zero MAC returned on a miss.
package ipv4_arp_cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RESP   = 2'd2
  } arp_state_e;

  localparam int CNT_W     = 32;
  localparam int MAC_W_DEF = 48;

  // Wide enough for any MAC_WIDTH up to the 64-bit management write bus.
  localparam logic [63:0] ZERO_MAC = 64'h0;

endpackage

// File: rtl/ipv4_arp_cam_bank_match.sv
// One search beat: compares BANKS table rows against the lookup address and
// reports the lowest-index valid match with its MAC.
module ipv4_arp_bank_match #(
  parameter  int BANKS     = 8,
  parameter  int MAC_WIDTH = 48,
  localparam int OFF_W     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic [BANKS-1:0]                vld,
  input  logic [BANKS-1:0][31:0]          ipv4,
  input  logic [BANKS-1:0][MAC_WIDTH-1:0] eth,
  input  logic [31:0]                     daddr,
  output logic                            hit,
  output logic [OFF_W-1:0]                off,
  output logic [MAC_WIDTH-1:0]            eth_out
);

  logic [BANKS-1:0] match;

  for (genvar g = 0; g < BANKS; g++) begin : g_lane
    assign match[g] = vld[g] && (ipv4[g] == daddr);
  end

  // Walk from the top down so the lowest matching lane is the last one written.
  always_comb begin
    hit     = |match;
    off     = '0;
    eth_out = '0;
    for (int b = BANKS - 1; b >= 0; b--) begin
      if (match[b]) begin
        off     = OFF_W'(b);
        eth_out = eth[b];
      end
    end
  end

endmodule

// File: rtl/ipv4_arp_cam.sv
// IPv4->MAC ARP table with banked multi-cycle search, management read/write/
// clear port and saturating hit/miss statistics.
module ipv4_arp_cam
  import ipv4_arp_cam_pkg::*;
#(
  parameter  int ROWS      = 32,
  parameter  int BANKS     = 8,
  parameter  int MAC_WIDTH = MAC_W_DEF,
  localparam int ROW_BITS  = $clog2(ROWS)
) (
  input  logic                 Bus2IP_Clk,
  input  logic                 reset,
  input  logic                 i_rd_req,
  input  logic [ROW_BITS-1:0]  i_rd_addr,
  output logic                 o_rd_ack,
  output logic [31:0]          o_rd_ipv4,
  output logic [MAC_WIDTH-1:0] o_rd_eth,
  output logic                 o_rd_vld,
  input  logic                 i_wr_req,
  input  logic [ROW_BITS-1:0]  i_wr_addr,
  input  logic [31:0]          i_wr_ipv4,
  input  logic [63:0]          i_wr_eth,
  input  logic                 i_wr_vld,
  output logic                 o_wr_ack,
  input  logic                 i_clr_req,
  output logic                 o_clr_ack,
  input  logic                 i_lk_valid,
  output logic                 o_lk_ready,
  input  logic [31:0]          i_lk_daddr,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic                 o_res_found,
  output logic [MAC_WIDTH-1:0] o_res_eth,
  output logic [ROW_BITS-1:0]  o_res_row,
  input  logic                 i_cnt_clr,
  output logic [CNT_W-1:0]     o_hit_cnt,
  output logic [CNT_W-1:0]     o_miss_cnt
);

  localparam int BEATS  = ROWS / BANKS;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = (BANKS > 1) ? $clog2(BANKS) : 1;

  if ((ROWS % BANKS) != 0) begin : g_bad_cfg
    $error("ipv4_arp_cam: ROWS must be a multiple of BANKS");
  end

  // Table storage
  logic [ROWS-1:0][31:0]          ipv4_q;
  logic [ROWS-1:0][MAC_WIDTH-1:0] eth_q;
  logic [ROWS-1:0]                vld_q;

  arp_state_e state_q, state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic [31:0]         daddr_q;
  logic                lk_accept, beat_inc, srch_done, last_beat;
  logic                found_q;
  logic [MAC_WIDTH-1:0] res_eth_q;
  logic [ROW_BITS-1:0] res_row_q;

  logic [BANKS-1:0]                bk_vld;
  logic [BANKS-1:0][31:0]          bk_ipv4;
  logic [BANKS-1:0][MAC_WIDTH-1:0] bk_eth;
  logic [ROW_BITS-1:0]             base_row;
  logic                            bm_hit;
  logic [OFF_W-1:0]                bm_off;
  logic [MAC_WIDTH-1:0]            bm_eth;

  logic rd_ack_q, wr_ack_q, clr_ack_q, tbl_free, clr_go, wr_go;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;
  logic unused_wr_eth;

  assign unused_wr_eth = &{1'b0, i_wr_eth};

  // ---------------- search datapath ----------------
  assign base_row  = ROW_BITS'(32'(beat_q) * BANKS);
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    bk_vld  = '0;
    bk_ipv4 = '0;
    bk_eth  = '0;
    for (int b = 0; b < BANKS; b++) begin
      bk_vld[b]  = vld_q[base_row + ROW_BITS'(b)];
      bk_ipv4[b] = ipv4_q[base_row + ROW_BITS'(b)];
      bk_eth[b]  = eth_q[base_row + ROW_BITS'(b)];
    end
  end

  ipv4_arp_bank_match #(
    .BANKS     (BANKS),
    .MAC_WIDTH (MAC_WIDTH)
  ) u_match (
    .vld     (bk_vld),
    .ipv4    (bk_ipv4),
    .eth     (bk_eth),
    .daddr   (daddr_q),
    .hit     (bm_hit),
    .off     (bm_off),
    .eth_out (bm_eth)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    lk_accept   = 1'b0;
    beat_inc    = 1'b0;
    srch_done   = 1'b0;
    o_lk_ready  = 1'b0;
    o_res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_lk_ready = 1'b1;
        if (i_lk_valid) begin
          lk_accept = 1'b1;
          state_d   = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (bm_hit || last_beat) begin
          srch_done = 1'b1;
          state_d   = ST_RESP;
        end else begin
          beat_inc = 1'b1;
        end
      end
      ST_RESP: begin
        o_res_valid = 1'b1;
        if (i_res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) begin
      daddr_q   <= '0;
      beat_q    <= '0;
      found_q   <= 1'b0;
      res_eth_q <= '0;
      res_row_q <= '0;
    end else begin
      if (lk_accept) begin
        daddr_q <= i_lk_daddr;
        beat_q  <= '0;
      end
      if (beat_inc) beat_q <= beat_q + 1'b1;
      if (srch_done) begin
        found_q   <= bm_hit;
        res_eth_q <= bm_hit ? bm_eth : ZERO_MAC[MAC_WIDTH-1:0];
        res_row_q <= bm_hit ? (base_row + ROW_BITS'(bm_off)) : '0;
      end
    end
  end

  assign o_res_found = found_q;
  assign o_res_eth   = res_eth_q;
  assign o_res_row   = res_row_q;

  // ---------------- management port ----------------
  // Reads always win; clear/write wait out a search and ignore the req level
  // during their own ack cycle.
  assign tbl_free = (state_q != ST_SEARCH);
  assign clr_go   = i_clr_req && !clr_ack_q && !i_rd_req && tbl_free;
  assign wr_go    = i_wr_req && !wr_ack_q && !i_rd_req && !clr_go && tbl_free;

  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) begin
      ipv4_q <= '0;
      eth_q  <= '0;
      vld_q  <= '0;
    end else if (clr_go) begin
      vld_q <= '0;
    end else if (wr_go) begin
      ipv4_q[i_wr_addr] <= i_wr_ipv4;
      eth_q[i_wr_addr]  <= i_wr_eth[MAC_WIDTH-1:0];
      vld_q[i_wr_addr]  <= i_wr_vld;
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (reset) begin
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      clr_ack_q <= 1'b0;
      o_rd_ipv4 <= '0;
      o_rd_eth  <= '0;
      o_rd_vld  <= 1'b0;
    end else begin
      rd_ack_q  <= i_rd_req;
      wr_ack_q  <= wr_go;
      clr_ack_q <= clr_go;
      if (i_rd_req) begin
        o_rd_ipv4 <= ipv4_q[i_rd_addr];
        o_rd_eth  <= eth_q[i_rd_addr];
        o_rd_vld  <= vld_q[i_rd_addr];
      end
    end
  end

  assign o_rd_ack  = rd_ack_q;
  assign o_wr_ack  = wr_ack_q;
  assign o_clr_ack = clr_ack_q;

  // ---------------- statistics ----------------
  always_ff @(posedge Bus2IP_Clk) begin
    if (reset || i_cnt_clr) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (srch_done) begin
      if (bm_hit && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (!bm_hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign o_hit_cnt  = hit_cnt_q;
  assign o_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_ipv4_arp_cam.sv
// Directed self-checking bench for ipv4_arp_cam at default parameters.
module tb_ipv4_arp_cam;

  logic        Bus2IP_Clk = 1'b0;
  logic        reset;
  logic        i_rd_req;
  logic [4:0]  i_rd_addr;
  logic        o_rd_ack;
  logic [31:0] o_rd_ipv4;
  logic [47:0] o_rd_eth;
  logic        o_rd_vld;
  logic        i_wr_req;
  logic [4:0]  i_wr_addr;
  logic [31:0] i_wr_ipv4;
  logic [63:0] i_wr_eth;
  logic        i_wr_vld;
  logic        o_wr_ack;
  logic        i_clr_req;
  logic        o_clr_ack;
  logic        i_lk_valid;
  logic        o_lk_ready;
  logic [31:0] i_lk_daddr;
  logic        o_res_valid;
  logic        i_res_ready;
  logic        o_res_found;
  logic [47:0] o_res_eth;
  logic [4:0]  o_res_row;
  logic        i_cnt_clr;
  logic [31:0] o_hit_cnt;
  logic [31:0] o_miss_cnt;

  int errors = 0;
  int checks = 0;

  ipv4_arp_cam dut (
    .Bus2IP_Clk (Bus2IP_Clk), .reset (reset),
    .i_rd_req (i_rd_req), .i_rd_addr (i_rd_addr), .o_rd_ack (o_rd_ack),
    .o_rd_ipv4 (o_rd_ipv4), .o_rd_eth (o_rd_eth), .o_rd_vld (o_rd_vld),
    .i_wr_req (i_wr_req), .i_wr_addr (i_wr_addr), .i_wr_ipv4 (i_wr_ipv4),
    .i_wr_eth (i_wr_eth), .i_wr_vld (i_wr_vld), .o_wr_ack (o_wr_ack),
    .i_clr_req (i_clr_req), .o_clr_ack (o_clr_ack),
    .i_lk_valid (i_lk_valid), .o_lk_ready (o_lk_ready), .i_lk_daddr (i_lk_daddr),
    .o_res_valid (o_res_valid), .i_res_ready (i_res_ready),
    .o_res_found (o_res_found), .o_res_eth (o_res_eth), .o_res_row (o_res_row),
    .i_cnt_clr (i_cnt_clr), .o_hit_cnt (o_hit_cnt), .o_miss_cnt (o_miss_cnt)
  );

  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Bus2IP_Clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] ip, input logic [47:0] mac,
                    input logic v);
    int n = 0;
    i_wr_addr = a; i_wr_ipv4 = ip; i_wr_eth = {16'hDEAD, mac}; i_wr_vld = v;
    i_wr_req = 1'b1;
    do begin tick(); n++; end while (!o_wr_ack && n < 20);
    i_wr_req = 1'b0;
    chk("wr_ack", o_wr_ack, 1'b1);
  endtask

  task automatic rd(input logic [4:0] a);
    i_rd_addr = a; i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    chk("rd_ack", o_rd_ack, 1'b1);
  endtask

  // Cycle 1 is the first cycle after the accepting edge; returns the cycle in
  // which o_res_valid is first seen.
  task automatic lookup(input logic [31:0] ip, output int cyc);
    i_lk_daddr = ip; i_lk_valid = 1'b1;
    tick();
    i_lk_valid = 1'b0;
    cyc = 1;
    while (!o_res_valid && cyc < 40) begin tick(); cyc++; end
  endtask

  task automatic accept();
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    chk("lk_ready_after_accept", o_lk_ready, 1'b1);
    chk("res_valid_after_accept", o_res_valid, 1'b0);
  endtask

  initial begin
    int cyc, res_cyc, ack_cyc;
    logic stable;
    reset = 1'b1;
    i_rd_req = 0; i_rd_addr = 0; i_wr_req = 0; i_wr_addr = 0; i_wr_ipv4 = 0;
    i_wr_eth = 0; i_wr_vld = 0; i_clr_req = 0; i_lk_valid = 0; i_lk_daddr = 0;
    i_res_ready = 0; i_cnt_clr = 0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_lk_ready", o_lk_ready, 1'b1);
    chk("rst_res_valid", o_res_valid, 1'b0);
    chk("rst_wr_ack", o_wr_ack, 1'b0);
    chk("rst_rd_ack", o_rd_ack, 1'b0);
    chk("rst_hit_cnt", o_hit_cnt, 0);
    chk("rst_miss_cnt", o_miss_cnt, 0);

    // 1: hit in row 17 (beat 2 -> 3 beats -> valid in cycle 4)
    wr(5'd17, 32'h0A000001, 48'h001122334455, 1'b1);
    lookup(32'h0A000001, cyc);
    chk("t1_cycle", cyc, 4);
    chk("t1_found", o_res_found, 1'b1);
    chk("t1_eth", o_res_eth, 48'h001122334455);
    chk("t1_row", o_res_row, 17);
    chk("t1_hit_cnt", o_hit_cnt, 1);
    accept();

    // 2: full miss
    lookup(32'h0A000009, cyc);
    chk("t2_cycle", cyc, 5);
    chk("t2_found", o_res_found, 1'b0);
    chk("t2_eth", o_res_eth, 0);
    chk("t2_row", o_res_row, 0);
    chk("t2_miss_cnt", o_miss_cnt, 1);
    accept();

    // 3: duplicate address, lowest row wins; delete it and the other shows
    wr(5'd3, 32'h0A000002, 48'hAAAAAAAAAA03, 1'b1);
    wr(5'd20, 32'h0A000002, 48'hBBBBBBBBBB14, 1'b1);
    lookup(32'h0A000002, cyc);
    chk("t3a_cycle", cyc, 2);
    chk("t3a_row", o_res_row, 3);
    chk("t3a_eth", o_res_eth, 48'hAAAAAAAAAA03);
    accept();
    wr(5'd3, 32'h0A000002, 48'hAAAAAAAAAA03, 1'b0);
    lookup(32'h0A000002, cyc);
    chk("t3b_cycle", cyc, 4);
    chk("t3b_row", o_res_row, 20);
    chk("t3b_hit_cnt", o_hit_cnt, 3);
    accept();

    // 4: write raised mid-search waits for SEARCH to end
    i_lk_daddr = 32'h0A000007; i_lk_valid = 1'b1;
    tick();
    i_lk_valid = 1'b0;
    cyc = 1;
    tick(); cyc++;
    i_wr_addr = 5'd30; i_wr_ipv4 = 32'h0A000007; i_wr_eth = 64'h0000_0707_0707_0707;
    i_wr_vld = 1'b1; i_wr_req = 1'b1;
    res_cyc = 0; ack_cyc = 0;
    while (ack_cyc == 0 && cyc < 30) begin
      tick(); cyc++;
      if (o_res_valid && res_cyc == 0) res_cyc = cyc;
      if (o_wr_ack) begin ack_cyc = cyc; i_wr_req = 1'b0; end
    end
    chk("t4_res_cycle", res_cyc, 5);
    chk("t4_ack_cycle", ack_cyc, 6);
    chk("t4_found_old_table", o_res_found, 1'b0);
    chk("t4_miss_cnt", o_miss_cnt, 2);
    accept();
    rd(5'd30);
    chk("t4_rd_ipv4", o_rd_ipv4, 32'h0A000007);
    chk("t4_rd_vld", o_rd_vld, 1'b1);
    lookup(32'h0A000007, cyc);
    chk("t4_new_row", o_res_row, 30);
    chk("t4_new_cycle", cyc, 5);
    accept();

    // 5: backpressure holds the result; lookups ignored meanwhile
    lookup(32'h0A000001, cyc);
    i_lk_daddr = 32'h0A000002; i_lk_valid = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      tick();
      stable &= o_res_valid && !o_lk_ready && o_res_found && (o_res_row == 5'd17)
                && (o_res_eth == 48'h001122334455);
    end
    chk("t5_stable", stable, 1'b1);
    i_lk_valid = 1'b0;
    accept();
    chk("t5_hit_cnt", o_hit_cnt, 5);

    // management read hold
    rd(5'd17);
    chk("rd_eth", o_rd_eth, 48'h001122334455);
    tick();
    chk("rd_ack_pulse", o_rd_ack, 1'b0);
    chk("rd_hold_ipv4", o_rd_ipv4, 32'h0A000001);

    // 6: clear invalidates but keeps contents
    i_clr_req = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!o_clr_ack && cyc < 20);
    i_clr_req = 1'b0;
    chk("t6_clr_ack", o_clr_ack, 1'b1);
    lookup(32'h0A000001, cyc);
    chk("t6_found", o_res_found, 1'b0);
    chk("t6_miss_cnt", o_miss_cnt, 3);
    accept();
    rd(5'd17);
    chk("t6_rd_vld", o_rd_vld, 1'b0);
    chk("t6_rd_ipv4", o_rd_ipv4, 32'h0A000001);
    chk("t6_rd_eth", o_rd_eth, 48'h001122334455);

    // saturation
    wr(5'd17, 32'h0A000001, 48'h001122334455, 1'b1);
    force dut.hit_cnt_q = 32'hFFFFFFFF;
    tick();
    release dut.hit_cnt_q;
    tick();
    chk("sat_preset", o_hit_cnt, 32'hFFFFFFFF);
    lookup(32'h0A000001, cyc);
    chk("sat_found", o_res_found, 1'b1);
    chk("sat_hit_cnt", o_hit_cnt, 32'hFFFFFFFF);
    accept();
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
    chk("cnt_clr_hit", o_hit_cnt, 0);
    chk("cnt_clr_miss", o_miss_cnt, 0);

    // read beats write in the same cycle; write follows
    i_rd_addr = 5'd17; i_rd_req = 1'b1;
    i_wr_addr = 5'd9; i_wr_ipv4 = 32'h0A000009; i_wr_eth = 64'h1; i_wr_vld = 1'b1;
    i_wr_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    chk("prio_rd_ack", o_rd_ack, 1'b1);
    chk("prio_wr_wait", o_wr_ack, 1'b0);
    tick();
    chk("prio_wr_ack", o_wr_ack, 1'b1);
    i_wr_req = 1'b0;
    tick();
    chk("wr_ack_pulse", o_wr_ack, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
